// File: rtl/imem_prog_loader_if.sv
// Field-bundle stream into the instruction loader.
// The producer drives the fields; the loader answers with in_ready.
interface imem_prog_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs;
  logic [3:0]  in_rt;
  logic [11:0] in_imm;

  modport master (
    output in_valid,
    output in_op,
    output in_rd,
    output in_rs,
    output in_rt,
    output in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_rd,
    input  in_rs,
    input  in_rt,
    input  in_imm,
    output in_ready
  );
endinterface

// File: rtl/imem_prog_loader.sv
// Packs decoded fields into 16-bit words and streams them into imem.
// Holds the core in reset until HLT is loaded or memory fills up.
module imem_prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_prog_loader_if.slave s,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERR
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDZ = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_LHB  = 4'hA;
  localparam logic [3:0] OP_LLB  = 4'hB;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_JAL  = 4'hD;
  localparam logic [3:0] OP_JR   = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [15:0] enc;
  logic        imm_ok;
  logic        hs;
  logic        last;

  assign hs   = (state_q == LOAD) && s.in_valid;
  assign last = &ptr_q;

  // Field packing and immediate sign-range check for the current op
  always_comb begin
    enc    = 16'h0000;
    imm_ok = 1'b1;
    unique case (s.in_op)
      OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR,
      OP_SLL, OP_SRL, OP_SRA: begin
        enc = {s.in_op, s.in_rd, s.in_rs, s.in_rt};
      end
      OP_LW, OP_SW: begin
        enc    = {s.in_op, s.in_rd, s.in_rs, s.in_imm[3:0]};
        imm_ok = (&s.in_imm[11:3]) | ~(|s.in_imm[11:3]);
      end
      OP_LHB, OP_LLB: begin
        enc    = {s.in_op, s.in_rd, s.in_imm[7:0]};
        imm_ok = (&s.in_imm[11:7]) | ~(|s.in_imm[11:7]);
      end
      OP_B: begin
        enc    = {s.in_op, s.in_rd[2:0], s.in_imm[8:0]};
        imm_ok = (&s.in_imm[11:8]) | ~(|s.in_imm[11:8]);
      end
      OP_JAL: begin
        enc = {s.in_op, s.in_imm};
      end
      OP_JR: begin
        enc = {s.in_op, 4'h0, s.in_rs, 4'h0};
      end
      OP_HLT: begin
        enc = 16'hF000;
      end
    endcase
  end

  // Next state and write datapath; start overrides any handshake
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (start) begin
      state_d = LOAD;
      addr_d  = '0;
      wdata_d = '0;
      ptr_d   = '0;
      count_d = '0;
    end else if (hs) begin
      if (!imm_ok) begin
        state_d = ERR;
      end else begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = enc;
        ptr_d   = ptr_q + 1'b1;
        count_d = count_q + 1'b1;
        if (s.in_op == OP_HLT || last) begin
          state_d = DONE;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign s.in_ready  = (state_q == LOAD);
  assign busy        = (state_q == LOAD);
  assign done        = (state_q == DONE);
  assign err         = (state_q == ERR);
  assign cpu_hold    = (state_q != DONE);
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign count       = count_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Bench for imem_prog_loader: two instances (256 and 4 words deep)
// share one random stream; a scoreboard tracks expected writes/state.
module tb_imem_prog_loader;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  imem_prog_loader_if if8();
  imem_prog_loader_if if2();

  assign if2.in_valid = if8.in_valid;
  assign if2.in_op    = if8.in_op;
  assign if2.in_rd    = if8.in_rd;
  assign if2.in_rs    = if8.in_rs;
  assign if2.in_rt    = if8.in_rt;
  assign if2.in_imm   = if8.in_imm;

  logic        we8, hold8, busy8, done8, err8;
  logic [7:0]  addr8;
  logic [15:0] wdata8;
  logic [8:0]  cnt8;
  logic        we2, hold2, busy2, done2, err2;
  logic [1:0]  addr2;
  logic [15:0] wdata2;
  logic [2:0]  cnt2;

  imem_prog_loader #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .s(if8),
    .imem_we(we8), .imem_addr(addr8), .imem_wdata(wdata8),
    .cpu_hold(hold8), .busy(busy8), .done(done8),
    .err(err8), .count(cnt8)
  );

  imem_prog_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .s(if2),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
    .cpu_hold(hold2), .busy(busy2), .done(done2),
    .err(err2), .count(cnt2)
  );

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // model: mode 0 idle, 1 loading, 2 done, 3 error
  int mode[2];
  int ptr[2];
  int cnt[2];
  bit exp_we[2];
  int depth[2] = '{256, 4};
  logic [23:0] q0[$];
  logic [23:0] q1[$];

  task automatic check(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_word(logic [3:0] op, logic [3:0] rd,
      logic [3:0] rs, logic [3:0] rt, logic [11:0] imm);
    int o, r, a, b, i, w;
    o = int'(op) * 4096;
    r = int'(rd);
    a = int'(rs);
    b = int'(rt);
    i = int'(imm);
    case (op)
      4'h8, 4'h9: w = o + r * 256 + a * 16 + i % 16;
      4'hA, 4'hB: w = o + r * 256 + i % 256;
      4'hC:       w = o + (r % 8) * 512 + i % 512;
      4'hD:       w = o + i;
      4'hE:       w = o + a * 16;
      4'hF:       w = 61440;
      default:    w = o + r * 256 + a * 16 + b;
    endcase
    return 16'(w);
  endfunction

  function automatic bit fits(logic [3:0] op, logic [11:0] imm);
    int v, n;
    v = int'(imm);
    if (v >= 2048) v = v - 4096;
    case (op)
      4'h8, 4'h9: n = 4;
      4'hA, 4'hB: n = 8;
      4'hC:       n = 9;
      default:    return 1'b1;
    endcase
    return (v >= -(1 << (n - 1))) && (v < (1 << (n - 1)));
  endfunction

  task automatic model_step(int k);
    logic [15:0] w;
    exp_we[k] = 1'b0;
    if (rst) begin
      mode[k] = 0;
      ptr[k] = 0;
      cnt[k] = 0;
      if (k == 0) q0.delete(); else q1.delete();
    end else if (start) begin
      mode[k] = 1;
      ptr[k] = 0;
      cnt[k] = 0;
    end else if (mode[k] == 1 && if8.in_valid) begin
      if (!fits(if8.in_op, if8.in_imm)) begin
        mode[k] = 3;
      end else begin
        w = ref_word(if8.in_op, if8.in_rd, if8.in_rs, if8.in_rt, if8.in_imm);
        if (k == 0) q0.push_back({8'(ptr[k]), w});
        else q1.push_back({8'(ptr[k]), w});
        exp_we[k] = 1'b1;
        ptr[k]++;
        cnt[k]++;
        if (if8.in_op == 4'hF || ptr[k] == depth[k]) mode[k] = 2;
      end
    end
  endtask

  task automatic chk_out(int k, logic we, logic [7:0] a, logic [15:0] d,
      logic rdy, logic bz, logic hold, logic dn, logic er, int c);
    logic [23:0] e;
    check("imem_we", k, 32'(we), 32'(exp_we[k]));
    if (exp_we[k]) begin
      e = 'x;
      if (k == 0 && q0.size() > 0) e = q0.pop_front();
      if (k == 1 && q1.size() > 0) e = q1.pop_front();
      check("imem_addr", k, 32'(a), 32'(e[23:16]));
      check("imem_wdata", k, 32'(d), 32'(e[15:0]));
    end
    check("in_ready", k, 32'(rdy), 32'(mode[k] == 1));
    check("busy", k, 32'(bz), 32'(mode[k] == 1));
    check("done", k, 32'(dn), 32'(mode[k] == 2));
    check("err", k, 32'(er), 32'(mode[k] == 3));
    check("cpu_hold", k, 32'(hold), 32'(mode[k] != 2));
    check("count", k, 32'(c), 32'(cnt[k]));
  endtask

  // monitor: compare both instances against the model mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      chk_out(0, we8, addr8, wdata8, if8.in_ready, busy8, hold8,
              done8, err8, int'(cnt8));
      chk_out(1, we2, 8'(addr2), wdata2, if2.in_ready, busy2, hold2,
              done2, err2, int'(cnt2));
    end
  end

  task automatic step(bit st, bit v, logic [3:0] op, logic [3:0] rd,
      logic [3:0] rs, logic [3:0] rt, logic [11:0] imm);
    start = st;
    if8.in_valid = v;
    if8.in_op = op;
    if8.in_rd = rd;
    if8.in_rs = rs;
    if8.in_rt = rt;
    if8.in_imm = imm;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    start = 1'b0;
    if8.in_valid = 1'b0;
  endtask

  task automatic send(logic [3:0] op, logic [3:0] rd, logic [3:0] rs,
      logic [3:0] rt, logic [11:0] imm);
    step(1'b0, 1'b1, op, rd, rs, rt, imm);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000);
  endtask

  task automatic go();
    step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000);
  endtask

  task automatic chk_bus_zero();
    check("rst_addr", 0, 32'(addr8), 32'h0);
    check("rst_wdata", 0, 32'(wdata8), 32'h0);
    check("rst_addr", 1, 32'(addr2), 32'h0);
    check("rst_wdata", 1, 32'(wdata2), 32'h0);
  endtask

  initial begin
    logic [11:0] imm;
    rst = 1'b1;
    start = 1'b0;
    if8.in_valid = 1'b0;
    if8.in_op = 4'h0;
    if8.in_rd = 4'h0;
    if8.in_rs = 4'h0;
    if8.in_rt = 4'h0;
    if8.in_imm = 12'h000;
    idle();
    mon_en = 1'b1;
    idle();
    chk_bus_zero();
    rst = 1'b0;
    idle();

    // single ADD
    go();
    send(4'h0, 4'h3, 4'h1, 4'h2, 12'h000);
    idle();

    // back-to-back stream
    go();
    send(4'h8, 4'h5, 4'h6, 4'h0, 12'hFFD);
    send(4'hB, 4'h4, 4'h0, 4'h0, 12'hFA5);
    send(4'hC, 4'h3, 4'h0, 4'h0, 12'hFFF);
    send(4'hD, 4'h0, 4'h0, 4'h0, 12'h123);
    send(4'hE, 4'h0, 4'h7, 4'h0, 12'h000);
    idle();

    // HLT after two words, then a dropped bundle
    go();
    send(4'h2, 4'h1, 4'h2, 4'h3, 12'h000);
    send(4'h4, 4'h5, 4'h6, 4'h7, 12'h000);
    send(4'hF, 4'h0, 4'h0, 4'h0, 12'h000);
    send(4'h0, 4'h1, 4'h1, 4'h1, 12'h000);
    idle();

    // out-of-range LW, then restart
    go();
    send(4'h8, 4'h1, 4'h2, 4'h0, 12'h008);
    send(4'h0, 4'h1, 4'h1, 4'h1, 12'h000);
    go();
    send(4'h0, 4'h9, 4'h8, 4'h7, 12'h000);
    idle();

    // four ADDs fill the shallow instance
    go();
    for (int i = 0; i < 5; i++) send(4'h0, 4'(i), 4'(i + 1), 4'(i + 2), 12'h000);
    idle();

    // start coincident with a handshake
    go();
    send(4'h0, 4'h1, 4'h2, 4'h3, 12'h000);
    send(4'h1, 4'h4, 4'h5, 4'h6, 12'h000);
    step(1'b1, 1'b1, 4'h3, 4'hA, 4'hB, 4'hC, 12'h000);
    send(4'h5, 4'h2, 4'h3, 4'h4, 12'h000);
    idle();

    // rst mid-stream
    go();
    send(4'h6, 4'h1, 4'h2, 4'h3, 12'h000);
    send(4'h7, 4'h4, 4'h5, 4'h6, 12'h000);
    rst = 1'b1;
    send(4'h0, 4'h7, 4'h8, 4'h9, 12'h000);
    chk_bus_zero();
    rst = 1'b0;
    idle();

    // fill the deep instance without HLT
    go();
    for (int i = 0; i < 258; i++)
      send(4'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom), 12'h000);
    idle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 1) imm = 12'($urandom_range(0, 4095));
      else imm = 12'(int'($urandom_range(0, 600)) - 300);
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
           4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), imm);
      rst = 1'b0;
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
